// File: rtl/regfile_pkg.sv
// Shared constants and the predecoded address bundle for the 64x24 4R/2W regfile front end.
package regfile_pkg;

    localparam int RF_DEPTH = 64;
    localparam int RF_AW    = 6;
    localparam int RF_DW    = 24;
    localparam int RF_NRD   = 4;
    localparam int RF_NWR   = 2;
    localparam int PREDEC_W = 12;

    // One-hot predecoded address groups, in array port order (c_na0 is the MSB).
    typedef struct packed {
        logic c_na0;
        logic c_a0;
        logic na1_na2;
        logic na1_a2;
        logic a1_na2;
        logic a1_a2;
        logic na3;
        logic a3;
        logic na4_na5;
        logic na4_a5;
        logic a4_na5;
        logic a4_a5;
    } predec_t;

endpackage

// File: rtl/regfile_predec.sv
// Binary-to-predecoded address converter for one array port; all terms low when the port is idle.
module regfile_predec
    import regfile_pkg::*;
(
    input  logic             v,
    input  logic [0:RF_AW-1] adr,
    output predec_t          pd
);

    // The a0 pair doubles as the port enable, so an idle port drives every term low.
    always_comb begin
        pd = '0;
        if (v) begin
            pd.c_na0   = ~adr[0];
            pd.c_a0    =  adr[0];
            pd.na1_na2 = ~adr[1] & ~adr[2];
            pd.na1_a2  = ~adr[1] &  adr[2];
            pd.a1_na2  =  adr[1] & ~adr[2];
            pd.a1_a2   =  adr[1] &  adr[2];
            pd.na3     = ~adr[3];
            pd.a3      =  adr[3];
            pd.na4_na5 = ~adr[4] & ~adr[5];
            pd.na4_a5  = ~adr[4] &  adr[5];
            pd.a4_na5  =  adr[4] & ~adr[5];
            pd.a4_a5   =  adr[4] &  adr[5];
        end
    end

endmodule

// File: rtl/regfile_4r2w_64x24_ctl.sv
// Port scheduler for the 64x24 4R/2W regfile: registers requests, predecodes them onto the array,
// drops the losing write of a same-address write pair and forwards in-flight write data to reads.
module regfile_4r2w_64x24_ctl
    import regfile_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd0_v, rd1_v, rd2_v, rd3_v,
    input  logic [0:RF_AW-1] rd0_adr, rd1_adr, rd2_adr, rd3_adr,
    output logic             rd0_dat_v, rd1_dat_v, rd2_dat_v, rd3_dat_v,
    output logic [0:RF_DW-1] rd0_dat, rd1_dat, rd2_dat, rd3_dat,
    input  logic             wr0_v, wr1_v,
    input  logic [0:RF_AW-1] wr0_adr, wr1_adr,
    input  logic [0:RF_DW-1] wr0_dat, wr1_dat,
    output logic arr_rd0_c_na0, arr_rd0_c_a0, arr_rd0_na1_na2, arr_rd0_na1_a2, arr_rd0_a1_na2, arr_rd0_a1_a2,
    output logic arr_rd0_na3, arr_rd0_a3, arr_rd0_na4_na5, arr_rd0_na4_a5, arr_rd0_a4_na5, arr_rd0_a4_a5,
    output logic arr_rd1_c_na0, arr_rd1_c_a0, arr_rd1_na1_na2, arr_rd1_na1_a2, arr_rd1_a1_na2, arr_rd1_a1_a2,
    output logic arr_rd1_na3, arr_rd1_a3, arr_rd1_na4_na5, arr_rd1_na4_a5, arr_rd1_a4_na5, arr_rd1_a4_a5,
    output logic arr_rd2_c_na0, arr_rd2_c_a0, arr_rd2_na1_na2, arr_rd2_na1_a2, arr_rd2_a1_na2, arr_rd2_a1_a2,
    output logic arr_rd2_na3, arr_rd2_a3, arr_rd2_na4_na5, arr_rd2_na4_a5, arr_rd2_a4_na5, arr_rd2_a4_a5,
    output logic arr_rd3_c_na0, arr_rd3_c_a0, arr_rd3_na1_na2, arr_rd3_na1_a2, arr_rd3_a1_na2, arr_rd3_a1_a2,
    output logic arr_rd3_na3, arr_rd3_a3, arr_rd3_na4_na5, arr_rd3_na4_a5, arr_rd3_a4_na5, arr_rd3_a4_a5,
    input  logic [0:RF_DW-1] arr_rd0_dat, arr_rd1_dat, arr_rd2_dat, arr_rd3_dat,
    output logic arr_wr0_c_na0, arr_wr0_c_a0, arr_wr0_na1_na2, arr_wr0_na1_a2, arr_wr0_a1_na2, arr_wr0_a1_a2,
    output logic arr_wr0_na3, arr_wr0_a3, arr_wr0_na4_na5, arr_wr0_na4_a5, arr_wr0_a4_na5, arr_wr0_a4_a5,
    output logic arr_wr1_c_na0, arr_wr1_c_a0, arr_wr1_na1_na2, arr_wr1_na1_a2, arr_wr1_a1_na2, arr_wr1_a1_a2,
    output logic arr_wr1_na3, arr_wr1_a3, arr_wr1_na4_na5, arr_wr1_na4_a5, arr_wr1_a4_na5, arr_wr1_a4_a5,
    output logic [0:RF_DW-1] arr_wr0_dat, arr_wr1_dat,
    output logic             wr_coll,
    output logic [CNT_W-1:0] wr_coll_cnt
);

    logic             rd_v_i   [RF_NRD];
    logic [0:RF_AW-1] rd_adr_i [RF_NRD];
    logic [0:RF_DW-1] arr_rd_i [RF_NRD];
    logic             wr_v_i   [RF_NWR];
    logic [0:RF_AW-1] wr_adr_i [RF_NWR];
    logic [0:RF_DW-1] wr_dat_i [RF_NWR];

    logic             rd_v_q   [RF_NRD];
    logic [0:RF_AW-1] rd_adr_q [RF_NRD];
    logic             wr_v_q   [RF_NWR];
    logic [0:RF_AW-1] wr_adr_q [RF_NWR];
    logic [0:RF_DW-1] wr_dat_q [RF_NWR];
    logic [0:RF_DW-1] rd_dat_o [RF_NRD];

    predec_t rd_pd [RF_NRD];
    predec_t wr_pd [RF_NWR];
    logic    coll;

    assign rd_v_i[0] = rd0_v;     assign rd_v_i[1] = rd1_v;     assign rd_v_i[2] = rd2_v;     assign rd_v_i[3] = rd3_v;
    assign rd_adr_i[0] = rd0_adr; assign rd_adr_i[1] = rd1_adr; assign rd_adr_i[2] = rd2_adr; assign rd_adr_i[3] = rd3_adr;
    assign arr_rd_i[0] = arr_rd0_dat; assign arr_rd_i[1] = arr_rd1_dat;
    assign arr_rd_i[2] = arr_rd2_dat; assign arr_rd_i[3] = arr_rd3_dat;
    assign wr_v_i[0] = wr0_v;     assign wr_v_i[1] = wr1_v;
    assign wr_adr_i[0] = wr0_adr; assign wr_adr_i[1] = wr1_adr;
    assign wr_dat_i[0] = wr0_dat; assign wr_dat_i[1] = wr1_dat;

    // Both writes to the same address: wr1 wins and wr0 is dropped before it reaches the array.
    assign coll = wr_v_i[0] & wr_v_i[1] & (wr_adr_i[0] == wr_adr_i[1]);

    // Request capture stage plus the collision pulse and its saturating counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_NRD; i++) begin
                rd_v_q[i]   <= 1'b0;
                rd_adr_q[i] <= '0;
            end
            for (int j = 0; j < RF_NWR; j++) begin
                wr_v_q[j]   <= 1'b0;
                wr_adr_q[j] <= '0;
                wr_dat_q[j] <= '0;
            end
            wr_coll     <= 1'b0;
            wr_coll_cnt <= '0;
        end else begin
            for (int i = 0; i < RF_NRD; i++) begin
                rd_v_q[i]   <= rd_v_i[i];
                rd_adr_q[i] <= rd_adr_i[i];
            end
            for (int j = 0; j < RF_NWR; j++) begin
                wr_adr_q[j] <= wr_adr_i[j];
                wr_dat_q[j] <= wr_dat_i[j];
            end
            wr_v_q[0] <= wr_v_i[0] & ~coll;
            wr_v_q[1] <= wr_v_i[1];
            wr_coll   <= coll;
            if (coll && (wr_coll_cnt != {CNT_W{1'b1}})) begin
                wr_coll_cnt <= wr_coll_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < RF_NRD; i++) begin : g_rd_pd
        regfile_predec u_pd (.v(rd_v_q[i]), .adr(rd_adr_q[i]), .pd(rd_pd[i]));
    end
    for (genvar j = 0; j < RF_NWR; j++) begin : g_wr_pd
        regfile_predec u_pd (.v(wr_v_q[j]), .adr(wr_adr_q[j]), .pd(wr_pd[j]));
    end

    // Read data mux: in-flight write data overrides the array, wr1 checked last so it takes priority.
    always_comb begin
        for (int i = 0; i < RF_NRD; i++) begin
            rd_dat_o[i] = arr_rd_i[i];
            if (BYPASS_EN && rd_v_q[i]) begin
                if (wr_v_q[0] && (wr_adr_q[0] == rd_adr_q[i])) rd_dat_o[i] = wr_dat_q[0];
                if (wr_v_q[1] && (wr_adr_q[1] == rd_adr_q[i])) rd_dat_o[i] = wr_dat_q[1];
            end
        end
    end

    assign rd0_dat_v = rd_v_q[0]; assign rd1_dat_v = rd_v_q[1]; assign rd2_dat_v = rd_v_q[2]; assign rd3_dat_v = rd_v_q[3];
    assign rd0_dat = rd_dat_o[0]; assign rd1_dat = rd_dat_o[1]; assign rd2_dat = rd_dat_o[2]; assign rd3_dat = rd_dat_o[3];
    assign arr_wr0_dat = wr_dat_q[0];
    assign arr_wr1_dat = wr_dat_q[1];

    assign {arr_rd0_c_na0, arr_rd0_c_a0, arr_rd0_na1_na2, arr_rd0_na1_a2, arr_rd0_a1_na2, arr_rd0_a1_a2,
            arr_rd0_na3, arr_rd0_a3, arr_rd0_na4_na5, arr_rd0_na4_a5, arr_rd0_a4_na5, arr_rd0_a4_a5} = rd_pd[0];
    assign {arr_rd1_c_na0, arr_rd1_c_a0, arr_rd1_na1_na2, arr_rd1_na1_a2, arr_rd1_a1_na2, arr_rd1_a1_a2,
            arr_rd1_na3, arr_rd1_a3, arr_rd1_na4_na5, arr_rd1_na4_a5, arr_rd1_a4_na5, arr_rd1_a4_a5} = rd_pd[1];
    assign {arr_rd2_c_na0, arr_rd2_c_a0, arr_rd2_na1_na2, arr_rd2_na1_a2, arr_rd2_a1_na2, arr_rd2_a1_a2,
            arr_rd2_na3, arr_rd2_a3, arr_rd2_na4_na5, arr_rd2_na4_a5, arr_rd2_a4_na5, arr_rd2_a4_a5} = rd_pd[2];
    assign {arr_rd3_c_na0, arr_rd3_c_a0, arr_rd3_na1_na2, arr_rd3_na1_a2, arr_rd3_a1_na2, arr_rd3_a1_a2,
            arr_rd3_na3, arr_rd3_a3, arr_rd3_na4_na5, arr_rd3_na4_a5, arr_rd3_a4_na5, arr_rd3_a4_a5} = rd_pd[3];
    assign {arr_wr0_c_na0, arr_wr0_c_a0, arr_wr0_na1_na2, arr_wr0_na1_a2, arr_wr0_a1_na2, arr_wr0_a1_a2,
            arr_wr0_na3, arr_wr0_a3, arr_wr0_na4_na5, arr_wr0_na4_a5, arr_wr0_a4_na5, arr_wr0_a4_a5} = wr_pd[0];
    assign {arr_wr1_c_na0, arr_wr1_c_a0, arr_wr1_na1_na2, arr_wr1_na1_a2, arr_wr1_a1_na2, arr_wr1_a1_a2,
            arr_wr1_na3, arr_wr1_a3, arr_wr1_na4_na5, arr_wr1_na4_a5, arr_wr1_a4_na5, arr_wr1_a4_a5} = wr_pd[1];

endmodule

// File: tb/tb_regfile_4r2w_64x24_ctl.sv
// Directed self-checking bench for the regfile port controller, with a behavioural 64x24 array model.
module tb_regfile_4r2w_64x24_ctl;

    logic        clk;
    logic        rst;
    logic        rd_v     [4];
    logic [0:5]  rd_adr   [4];
    wire         rd_dat_v [4];
    wire  [0:23] rd_dat   [4];
    logic [0:23] arr_rd_dat [4];
    wire  [11:0] rd_pd    [4];
    logic        wr_v     [2];
    logic [0:5]  wr_adr   [2];
    logic [0:23] wr_dat   [2];
    wire  [11:0] wr_pd    [2];
    wire  [0:23] arr_wr_dat [2];
    wire         wr_coll;
    wire  [7:0]  wr_coll_cnt;

    logic [0:23] mem [64];
    int total;
    int bad;

    regfile_4r2w_64x24_ctl #(.BYPASS_EN(1'b1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rd0_v(rd_v[0]), .rd1_v(rd_v[1]), .rd2_v(rd_v[2]), .rd3_v(rd_v[3]),
        .rd0_adr(rd_adr[0]), .rd1_adr(rd_adr[1]), .rd2_adr(rd_adr[2]), .rd3_adr(rd_adr[3]),
        .rd0_dat_v(rd_dat_v[0]), .rd1_dat_v(rd_dat_v[1]), .rd2_dat_v(rd_dat_v[2]), .rd3_dat_v(rd_dat_v[3]),
        .rd0_dat(rd_dat[0]), .rd1_dat(rd_dat[1]), .rd2_dat(rd_dat[2]), .rd3_dat(rd_dat[3]),
        .wr0_v(wr_v[0]), .wr1_v(wr_v[1]), .wr0_adr(wr_adr[0]), .wr1_adr(wr_adr[1]),
        .wr0_dat(wr_dat[0]), .wr1_dat(wr_dat[1]),
        .arr_rd0_c_na0(rd_pd[0][11]), .arr_rd0_c_a0(rd_pd[0][10]), .arr_rd0_na1_na2(rd_pd[0][9]), .arr_rd0_na1_a2(rd_pd[0][8]),
        .arr_rd0_a1_na2(rd_pd[0][7]), .arr_rd0_a1_a2(rd_pd[0][6]), .arr_rd0_na3(rd_pd[0][5]), .arr_rd0_a3(rd_pd[0][4]),
        .arr_rd0_na4_na5(rd_pd[0][3]), .arr_rd0_na4_a5(rd_pd[0][2]), .arr_rd0_a4_na5(rd_pd[0][1]), .arr_rd0_a4_a5(rd_pd[0][0]),
        .arr_rd1_c_na0(rd_pd[1][11]), .arr_rd1_c_a0(rd_pd[1][10]), .arr_rd1_na1_na2(rd_pd[1][9]), .arr_rd1_na1_a2(rd_pd[1][8]),
        .arr_rd1_a1_na2(rd_pd[1][7]), .arr_rd1_a1_a2(rd_pd[1][6]), .arr_rd1_na3(rd_pd[1][5]), .arr_rd1_a3(rd_pd[1][4]),
        .arr_rd1_na4_na5(rd_pd[1][3]), .arr_rd1_na4_a5(rd_pd[1][2]), .arr_rd1_a4_na5(rd_pd[1][1]), .arr_rd1_a4_a5(rd_pd[1][0]),
        .arr_rd2_c_na0(rd_pd[2][11]), .arr_rd2_c_a0(rd_pd[2][10]), .arr_rd2_na1_na2(rd_pd[2][9]), .arr_rd2_na1_a2(rd_pd[2][8]),
        .arr_rd2_a1_na2(rd_pd[2][7]), .arr_rd2_a1_a2(rd_pd[2][6]), .arr_rd2_na3(rd_pd[2][5]), .arr_rd2_a3(rd_pd[2][4]),
        .arr_rd2_na4_na5(rd_pd[2][3]), .arr_rd2_na4_a5(rd_pd[2][2]), .arr_rd2_a4_na5(rd_pd[2][1]), .arr_rd2_a4_a5(rd_pd[2][0]),
        .arr_rd3_c_na0(rd_pd[3][11]), .arr_rd3_c_a0(rd_pd[3][10]), .arr_rd3_na1_na2(rd_pd[3][9]), .arr_rd3_na1_a2(rd_pd[3][8]),
        .arr_rd3_a1_na2(rd_pd[3][7]), .arr_rd3_a1_a2(rd_pd[3][6]), .arr_rd3_na3(rd_pd[3][5]), .arr_rd3_a3(rd_pd[3][4]),
        .arr_rd3_na4_na5(rd_pd[3][3]), .arr_rd3_na4_a5(rd_pd[3][2]), .arr_rd3_a4_na5(rd_pd[3][1]), .arr_rd3_a4_a5(rd_pd[3][0]),
        .arr_rd0_dat(arr_rd_dat[0]), .arr_rd1_dat(arr_rd_dat[1]), .arr_rd2_dat(arr_rd_dat[2]), .arr_rd3_dat(arr_rd_dat[3]),
        .arr_wr0_c_na0(wr_pd[0][11]), .arr_wr0_c_a0(wr_pd[0][10]), .arr_wr0_na1_na2(wr_pd[0][9]), .arr_wr0_na1_a2(wr_pd[0][8]),
        .arr_wr0_a1_na2(wr_pd[0][7]), .arr_wr0_a1_a2(wr_pd[0][6]), .arr_wr0_na3(wr_pd[0][5]), .arr_wr0_a3(wr_pd[0][4]),
        .arr_wr0_na4_na5(wr_pd[0][3]), .arr_wr0_na4_a5(wr_pd[0][2]), .arr_wr0_a4_na5(wr_pd[0][1]), .arr_wr0_a4_a5(wr_pd[0][0]),
        .arr_wr1_c_na0(wr_pd[1][11]), .arr_wr1_c_a0(wr_pd[1][10]), .arr_wr1_na1_na2(wr_pd[1][9]), .arr_wr1_na1_a2(wr_pd[1][8]),
        .arr_wr1_a1_na2(wr_pd[1][7]), .arr_wr1_a1_a2(wr_pd[1][6]), .arr_wr1_na3(wr_pd[1][5]), .arr_wr1_a3(wr_pd[1][4]),
        .arr_wr1_na4_na5(wr_pd[1][3]), .arr_wr1_na4_a5(wr_pd[1][2]), .arr_wr1_a4_na5(wr_pd[1][1]), .arr_wr1_a4_a5(wr_pd[1][0]),
        .arr_wr0_dat(arr_wr_dat[0]), .arr_wr1_dat(arr_wr_dat[1]),
        .wr_coll(wr_coll), .wr_coll_cnt(wr_coll_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Recover the binary address the array would see from a predecoded group.
    function automatic logic [0:5] decodeAdr(input logic [11:0] pd);
        decodeAdr = {pd[10], pd[7] | pd[6], pd[8] | pd[6], pd[4], pd[1] | pd[0], pd[2] | pd[0]};
    endfunction

    // Array model: writes commit at the clock edge ending the enable cycle, wr1 landing last.
    always @(posedge clk) begin
        if (wr_pd[0][11] | wr_pd[0][10]) mem[decodeAdr(wr_pd[0])] <= arr_wr_dat[0];
        if (wr_pd[1][11] | wr_pd[1][10]) mem[decodeAdr(wr_pd[1])] <= arr_wr_dat[1];
    end

    // Array model read ports: idle ports return a recognisable junk value.
    always @* begin
        for (int i = 0; i < 4; i++) begin
            arr_rd_dat[i] = (rd_pd[i][11] | rd_pd[i][10]) ? mem[decodeAdr(rd_pd[i])] : 24'hEEEEEE;
        end
    end

    // Drive every request input for the next capture edge.
    task automatic applyStimulus(input logic [3:0] rv, input logic [0:5] ra0, input logic [0:5] ra1,
                                 input logic [0:5] ra2, input logic [0:5] ra3, input logic [1:0] wv,
                                 input logic [0:5] wa0, input logic [0:23] wd0,
                                 input logic [0:5] wa1, input logic [0:23] wd1);
        rd_v[0] = rv[0]; rd_v[1] = rv[1]; rd_v[2] = rv[2]; rd_v[3] = rv[3];
        rd_adr[0] = ra0; rd_adr[1] = ra1; rd_adr[2] = ra2; rd_adr[3] = ra3;
        wr_v[0] = wv[0]; wr_v[1] = wv[1];
        wr_adr[0] = wa0; wr_dat[0] = wd0;
        wr_adr[1] = wa1; wr_dat[1] = wd1;
    endtask

    task automatic idle();
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b00, 6'h00, 24'h0, 6'h00, 24'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed test sequence.
    initial begin
        total = 0;
        bad   = 0;
        for (int k = 0; k < 64; k++) mem[k] = 24'h5A0000 | 24'(k);
        rst = 1'b1;
        idle();

        // Reset state
        #3;
        checkOutput("rst_wr0_pd", 32'(wr_pd[0]), 32'h0);
        checkOutput("rst_wr1_pd", 32'(wr_pd[1]), 32'h0);
        checkOutput("rst_rd0_pd", 32'(rd_pd[0]), 32'h0);
        checkOutput("rst_rd3_pd", 32'(rd_pd[3]), 32'h0);
        checkOutput("rst_rd_dat_v", 32'({rd_dat_v[0], rd_dat_v[1], rd_dat_v[2], rd_dat_v[3]}), 32'h0);
        checkOutput("rst_wr_coll", 32'(wr_coll), 32'h0);
        checkOutput("rst_cnt", 32'(wr_coll_cnt), 32'h0);
        checkOutput("rst_wr0_dat", 32'(arr_wr_dat[0]), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single write, predecode of 6'h2A
        $display("[TB] write predecode");
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b01, 6'h2A, 24'hABCDEF, 6'h00, 24'h0);
        tick();
        idle();
        checkOutput("wr0_pd_2A", 32'(wr_pd[0]), 32'h522);
        checkOutput("wr0_dat_2A", 32'(arr_wr_dat[0]), 32'h00ABCDEF);
        checkOutput("wr1_pd_idle", 32'(wr_pd[1]), 32'h0);
        checkOutput("wr_coll_none", 32'(wr_coll), 32'h0);
        tick();

        // Write then read back through the array model
        $display("[TB] write then read");
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b01, 6'h05, 24'h123456, 6'h00, 24'h0);
        tick();
        idle();
        tick();
        applyStimulus(4'b0100, 6'h00, 6'h00, 6'h05, 6'h00, 2'b00, 6'h00, 24'h0, 6'h00, 24'h0);
        tick();
        idle();
        checkOutput("rd2_v", 32'(rd_dat_v[2]), 32'h1);
        checkOutput("rd0_v_idle", 32'(rd_dat_v[0]), 32'h0);
        checkOutput("rd2_pd_05", 32'(rd_pd[2]), 32'h A14);
        checkOutput("rd2_dat_05", 32'(rd_dat[2]), 32'h00123456);
        tick();

        // Reset in the middle of a write kills it before the array commits
        $display("[TB] reset mid write");
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b01, 6'h07, 24'h777777, 6'h00, 24'h0);
        tick();
        idle();
        checkOutput("wr0_pd_07", 32'(wr_pd[0]), 32'hA11);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_wr0_pd", 32'(wr_pd[0]), 32'h0);
        checkOutput("midrst_wr0_dat", 32'(arr_wr_dat[0]), 32'h0);
        #1;
        rst = 1'b0;
        applyStimulus(4'b0001, 6'h07, 6'h00, 6'h00, 6'h00, 2'b00, 6'h00, 24'h0, 6'h00, 24'h0);
        tick();
        idle();
        checkOutput("midrst_rd0_dat_07", 32'(rd_dat[0]), 32'h005A0007);
        tick();

        // Write-write collision on 6'h3F
        $display("[TB] write collision");
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b11, 6'h3F, 24'h111111, 6'h3F, 24'h222222);
        tick();
        idle();
        checkOutput("coll_wr0_pd", 32'(wr_pd[0]), 32'h0);
        checkOutput("coll_wr1_pd", 32'(wr_pd[1]), 32'h451);
        checkOutput("coll_pulse", 32'(wr_coll), 32'h1);
        checkOutput("coll_cnt1", 32'(wr_coll_cnt), 32'h1);
        tick();
        checkOutput("coll_pulse_end", 32'(wr_coll), 32'h0);
        applyStimulus(4'b0010, 6'h00, 6'h3F, 6'h00, 6'h00, 2'b00, 6'h00, 24'h0, 6'h00, 24'h0);
        tick();
        idle();
        checkOutput("coll_rd1_dat", 32'(rd_dat[1]), 32'h00222222);
        tick();

        // Same-cycle write and reads forward the write data
        $display("[TB] bypass");
        applyStimulus(4'b1001, 6'h10, 6'h00, 6'h00, 6'h10, 2'b10, 6'h00, 24'h0, 6'h10, 24'hCAFE00);
        tick();
        idle();
        checkOutput("byp_rd0_v", 32'(rd_dat_v[0]), 32'h1);
        checkOutput("byp_rd0_dat", 32'(rd_dat[0]), 32'h00CAFE00);
        checkOutput("byp_rd3_dat", 32'(rd_dat[3]), 32'h00CAFE00);
        tick();

        // Counter saturation under back-to-back collisions
        $display("[TB] counter saturation");
        applyStimulus(4'b0000, 6'h00, 6'h00, 6'h00, 6'h00, 2'b11, 6'h20, 24'h333333, 6'h20, 24'h444444);
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (n == 100) checkOutput("sat_cnt_mid", 32'(wr_coll_cnt), 32'd101);
        end
        checkOutput("sat_pulse_held", 32'(wr_coll), 32'h1);
        checkOutput("sat_cnt_ff", 32'(wr_coll_cnt), 32'hFF);
        idle();
        tick();
        checkOutput("sat_pulse_end", 32'(wr_coll), 32'h0);
        checkOutput("sat_cnt_hold", 32'(wr_coll_cnt), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_4r2w_64x24_ctl.md
Name: regfile_4r2w_64x24_ctl

Overview:
- Port scheduler and controller in front of the 64x24 4-read/2-write toysram regfile.
- Accepts binary-addressed read and write requests and registers them for one cycle. Drives the array's predecoded one-hot address groups, with enable encoded in the a0 pair.
- Resolves write-write collisions and forwards same-cycle write data to colliding reads, so the array never sees an ambiguous access.

Parameters:
- BYPASS_EN, 1: 1 = forward in-flight write data to same-address reads; 0 = read data always comes from the array.
- CNT_W, 8: width of the saturating collision counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdN_v  in  1  read request valid, N=0..3
- rdN_adr  in  [0:5]  read address, bit 0 = MSB
- rdN_dat_v  out  1  read data valid, one cycle after request
- rdN_dat  out  [0:23]  read data (bypass-muxed)
- wrM_v  in  1  write request valid, M=0..1
- wrM_adr  in  [0:5]  write address
- wrM_dat  in  [0:23]  write data
- arr_rdN_*  out  12x1  predecoded array read address: c_na0, c_a0, na1_na2, na1_a2, a1_na2, a1_a2, na3, a3, na4_na5, na4_a5, a4_na5, a4_a5
- arr_rdN_dat  in  [0:23]  array read data
- arr_wrM_*  out  12x1  predecoded array write address, same 12 signals
- arr_wrM_dat  out  [0:23]  array write data
- wr_coll  out  1  pulse: wr0 dropped due to collision
- wr_coll_cnt  out  [CNT_W-1:0]  saturating collision count

Behaviour:
- Reset (async, rst=1): all request registers invalid; every arr_* predecoded output 0 (enables off); arr_wrM_dat 0; rdN_dat_v 0; wr_coll 0; wr_coll_cnt 0. Reset asserted mid-operation kills in-flight requests immediately and no array write occurs.
- Stage S0 (edge N): capture rdN_v/adr and wrM_v/adr/dat into registers.
- Stage S1 (cycle N+1): predecode the registered address onto arr_* outputs; rdN_dat_v = registered rdN_v; rdN_dat is combinational from arr_rdN_dat or the bypass. Latency is 1 cycle; throughput is one request per port per cycle; no backpressure.
- Predecode, valid=1:
  - c_a0 = a0; c_na0 = ~a0.
  - Exactly one of the four a1/a2 terms is 1.
  - Exactly one of na3/a3 is 1.
  - Exactly one of the four a4/a5 terms is 1.
- Predecode, valid=0: all 12 signals are 0. The array sees enable 0 because c_na0 = c_a0 = 0.
- Write collision: wr0_v & wr1_v & wr0_adr==wr1_adr at S0 capture.
  - wr1 wins; wr0's registered valid is cleared.
  - wr_coll pulses high in S1 for 1 cycle.
  - wr_coll_cnt increments and saturates at all-ones.
- Bypass (BYPASS_EN=1), evaluated in S1:
  - If a registered read address equals a registered valid write address, rdN_dat = that write data.
  - wr1 has priority over wr0, which only arises when a collision did not clear wr0.
  - The array read result is ignored in this case.
- Bypass with BYPASS_EN=0: rdN_dat = arr_rdN_dat; the read-during-write result is undefined and the bench masks it.
- Invalid read (rdN_dat_v=0): rdN_dat = arr_rdN_dat, a don't-care value.
- Predecoded outputs come straight from flops through the predecode logic, so there is no glitch on enable-pair deassertion.

Decomposition:
- Package regfile_pkg:
  - constants RF_DEPTH=64, RF_AW=6, RF_DW=24, RF_NRD=4, RF_NWR=2, PREDEC_W=12
  - struct/typedef predec_t holding the 12 one-hot fields in port order
- Sub-module regfile_predec: combinational; inputs v and adr[0:5]; output predec_t. Instantiated 6 times, once per port.
- The controller holds the S0 registers, collision logic, counter and bypass muxes.

Test Plan:
- Reset then idle, rst pulsed mid-cycle -> all arr_* = 0 asynchronously, rdN_dat_v = 0, wr_coll_cnt = 0.
- wr0_v=1, adr=6'h2A (101010), dat=24'hABCDEF -> next cycle:
  - wr0 c_a0=1, c_na0=0, a1=0/a2=1 term (na1_a2)=1, a3=0 term (na3)=1, a4=1/a5=0 term (a4_na5)=1, all other terms 0
  - arr_wr0_dat = 24'hABCDEF
- Write 24'h123456 to 6'h05, then read rd2 6'h05 two cycles later with an array model -> rd2_dat_v=1 and rd2_dat=24'h123456 at latency 1.
- Same-cycle wr0 and wr1 to 6'h3F (dat 24'h111111 / 24'h222222) -> only arr_wr1 enabled; wr_coll=1 for 1 cycle; count=1; a later read returns 24'h222222.
- Same-cycle wr1 6'h10 = 24'hCAFE00 with rd0 and rd3 of 6'h10, BYPASS_EN=1 -> rd0_dat = rd3_dat = 24'hCAFE00 regardless of array output.
- 300 back-to-back collisions with CNT_W=8 -> wr_coll_cnt saturates at 8'hFF, no wrap.
